uart_tx_cfg: RTL and testbench

- Parametrised UART transmitter; next generation of the team's fixed 8-bit, one-clock-per-bit transmitter.
- Adds configurable data width, a runtime baud prescaler, an optional second stop bit and a frame-done pulse.
- Latches data and frame configuration at acceptance, then serialises start, data (LSB first), optional parity and stop bit(s) onto TX_OUT.
- Sits between the system-side producer (Data_valid / busy handshake) and the serial line pad.

---
 rtl/uart_tx_cfg_if.sv | 26 ++
 rtl/uart_tx_cfg.sv | 136 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Producer/serial-line bundle for uart_tx_cfg: request, frame configuration and
// the transmitter's line and status outputs.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic                      STOP_2;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      TX_OUT;
    logic                      busy;
    logic                      tx_done;

    modport master (
        output P_DATA, Data_valid, PAR_EN, PAR_TYP, STOP_2, PRESCALE,
        input  TX_OUT, busy, tx_done
    );

    modport slave (
        input  P_DATA, Data_valid, PAR_EN, PAR_TYP, STOP_2, PRESCALE,
        output TX_OUT, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable payload width, runtime baud prescaler,
// optional parity, optional second stop bit and a frame-done pulse.
module uart_tx_cfg #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_cfg_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      stop2_q, stop2_d;
    logic                      stop_sec_q, stop_sec_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bit_end;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            presc_q    <= ONE;
            cnt_q      <= '0;
            idx_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        bit_end    = (cnt_q == '0);

        if (state_q == S_IDLE) begin
            if (bus.Data_valid) begin
                data_d     = bus.P_DATA;
                par_en_d   = bus.PAR_EN;
                par_typ_d  = bus.PAR_TYP;
                stop2_d    = bus.STOP_2;
                presc_d    = (bus.PRESCALE == '0) ? ONE : bus.PRESCALE;
                cnt_d      = presc_d - ONE;
                idx_d      = '0;
                stop_sec_d = 1'b0;
                state_d    = S_START;
            end
        end else begin
            cnt_d = bit_end ? (presc_q - ONE) : (cnt_q - ONE);
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                    S_DATA: begin
                        if (idx_q == LAST_IDX) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    S_PARITY: state_d = S_STOP;
                    S_STOP: begin
                        if (stop2_q && !stop_sec_q) begin
                            stop_sec_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Line level is computed for the next state so TX_OUT comes straight from a flop.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[idx_d];
            S_PARITY: tx_d = (^data_d) ^ par_typ_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign bus.TX_OUT  = tx_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: 8-bit and 5-bit builds, expected line bits
// and frame lengths queued at stimulus time, checked as the frames appear.
module tb_uart_tx_cfg;
    logic clk;
    logic rst;

    uart_tx_cfg_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) ifa ();
    uart_tx_cfg_if #(.DATA_WIDTH(5), .PRESCALE_WIDTH(16)) ifb ();

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa.slave)
    );
    uart_tx_cfg #(.DATA_WIDTH(5), .PRESCALE_WIDTH(16)) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb.slave)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_a[$];
    logic exp_b[$];
    int   len_a[$];
    int   len_b[$];
    int   busy_cnt_a = 0;
    int   busy_cnt_b = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop bit(s), each held P cycles.
    task automatic push_frame(input int lane, input int dw, input logic [8:0] d,
                              input bit pe, input bit pt, input bit s2, input int presc);
        logic bits[$];
        logic par;
        int   p;
        p   = (presc == 0) ? 1 : presc;
        par = pt;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pe) bits.push_back(par);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < p; k++) begin
                if (lane == 0) exp_a.push_back(bits[i]);
                else           exp_b.push_back(bits[i]);
            end
        end
        if (lane == 0) len_a.push_back(bits.size() * p);
        else           len_b.push_back(bits.size() * p);
    endtask

    task automatic drive(input int lane, input logic [8:0] d, input bit pe, input bit pt,
                         input bit s2, input logic [15:0] presc, input bit dv);
        if (lane == 0) begin
            ifa.P_DATA = d[7:0]; ifa.PAR_EN = pe; ifa.PAR_TYP = pt;
            ifa.STOP_2 = s2; ifa.PRESCALE = presc; ifa.Data_valid = dv;
        end else begin
            ifb.P_DATA = d[4:0]; ifb.PAR_EN = pe; ifb.PAR_TYP = pt;
            ifb.STOP_2 = s2; ifb.PRESCALE = presc; ifb.Data_valid = dv;
        end
    endtask

    task automatic send(input int lane, input logic [8:0] d, input bit pe, input bit pt,
                        input bit s2, input logic [15:0] presc);
        @(negedge clk);
        drive(lane, d, pe, pt, s2, presc, 1'b1);
        push_frame(lane, (lane == 0) ? 8 : 5, d, pe, pt, s2, int'(presc));
        @(negedge clk);
        if (lane == 0) ifa.Data_valid = 1'b0;
        else           ifb.Data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || len_a.size() != 0 ||
                len_b.size() != 0 || ifa.busy || ifb.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.busy) begin
                busy_cnt_a++;
                if (exp_a.size() == 0) check("a_unexpected_busy", 32'(ifa.busy), 32'd0);
                else                   check("a_tx_bit", 32'(ifa.TX_OUT), 32'(exp_a.pop_front()));
            end else begin
                check("a_idle_line", 32'(ifa.TX_OUT), 32'd1);
            end
            if (ifa.tx_done) begin
                if (len_a.size() == 0) check("a_spurious_done", 32'(ifa.tx_done), 32'd0);
                else                   check("a_busy_len", 32'(busy_cnt_a), 32'(len_a.pop_front()));
                busy_cnt_a = 0;
            end
            if (ifb.busy) begin
                busy_cnt_b++;
                if (exp_b.size() == 0) check("b_unexpected_busy", 32'(ifb.busy), 32'd0);
                else                   check("b_tx_bit", 32'(ifb.TX_OUT), 32'(exp_b.pop_front()));
            end else begin
                check("b_idle_line", 32'(ifb.TX_OUT), 32'd1);
            end
            if (ifb.tx_done) begin
                if (len_b.size() == 0) check("b_spurious_done", 32'(ifb.tx_done), 32'd0);
                else                   check("b_busy_len", 32'(busy_cnt_b), 32'(len_b.pop_front()));
                busy_cnt_b = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        drive(0, 9'h000, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
        drive(1, 9'h000, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
        #1;
        check("reset_tx_out", 32'(ifa.TX_OUT), 32'd1);
        check("reset_busy", 32'(ifa.busy), 32'd0);
        check("reset_tx_done", 32'(ifa.tx_done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 0xA5, even parity, P=1
        send(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 16'd1);
        wait_idle("even_parity_done", 100);

        // 0x00, odd parity, two stop bits
        send(0, 9'h000, 1'b1, 1'b1, 1'b1, 16'd1);
        wait_idle("odd_parity_2stop_done", 100);

        // P=4 frame; inputs disturbed while in flight
        send(0, 9'h0FF, 1'b0, 1'b0, 1'b1, 16'd4);
        @(negedge clk);
        drive(0, 9'h000, 1'b1, 1'b1, 1'b0, 16'd9, 1'b0);
        wait_idle("prescale4_done", 200);

        // PRESCALE=0 behaves as 1; a request while busy is dropped
        send(0, 9'h05A, 1'b0, 1'b0, 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        drive(0, 9'h03C, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
        @(negedge clk);
        ifa.Data_valid = 1'b0;
        wait_idle("prescale0_done", 100);

        // Data_valid held high: back-to-back frames, one idle cycle between them
        @(negedge clk);
        drive(0, 9'h033, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
        push_frame(0, 8, 9'h033, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);
        ifa.P_DATA = 8'hC6;
        push_frame(0, 8, 9'h0C6, 1'b0, 1'b0, 1'b0, 1);
        n = 0;
        while (!ifa.tx_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done_seen", 32'(n < 40), 32'd1);
        check("b2b_gap_busy_low", 32'(ifa.busy), 32'd0);
        @(negedge clk);
        check("b2b_second_started", 32'(ifa.busy), 32'd1);
        ifa.Data_valid = 1'b0;
        wait_idle("b2b_done", 100);

        // Async reset during DATA bit 3 (0x07 sends 0 there), P=2
        send(0, 9'h007, 1'b0, 1'b0, 1'b0, 16'd2);
        repeat (8) @(negedge clk);
        check("pre_reset_bit3", 32'(ifa.TX_OUT), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx_out", 32'(ifa.TX_OUT), 32'd1);
        check("async_rst_busy", 32'(ifa.busy), 32'd0);
        check("async_rst_tx_done", 32'(ifa.tx_done), 32'd0);
        exp_a.delete();
        len_a.delete();
        busy_cnt_a = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_idle_busy", 32'(ifa.busy), 32'd0);
        send(0, 9'h081, 1'b1, 1'b1, 1'b0, 16'd1);
        wait_idle("post_reset_frame_done", 100);

        // 5-bit build
        send(1, 9'h015, 1'b1, 1'b0, 1'b0, 16'd1);
        wait_idle("w5_even_done", 100);
        send(1, 9'h01F, 1'b1, 1'b1, 1'b1, 16'd3);
        wait_idle("w5_odd_p3_done", 200);

        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
